// File: rtl/lut_cfg_ctrl_if.sv
// Bundle between the bitstream loader, the LUT configuration sequencer and the LUTRAM write port.
// The loader side uses master; the sequencer uses slave.
interface lut_cfg_ctrl_if #(
    parameter int NUM_LUTS = 8,
    parameter int LUT_K    = 6,
    parameter int ID_W     = 3
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [ID_W-1:0]       cfg_lut_id;
    logic [2**LUT_K-1:0]   cfg_data;
    logic                  cfg_pause;
    logic [LUT_K-1:0]      lut_a;
    logic                  lut_d;
    logic [NUM_LUTS-1:0]   lut_we;
    logic                  cfg_busy;
    logic                  cfg_done;
    logic                  cfg_err;
    logic [NUM_LUTS-1:0]   lut_configured;

    modport master (
        output cfg_valid, cfg_lut_id, cfg_data, cfg_pause,
        input  cfg_ready, lut_a, lut_d, lut_we, cfg_busy, cfg_done, cfg_err, lut_configured
    );

    modport slave (
        input  cfg_valid, cfg_lut_id, cfg_data, cfg_pause,
        output cfg_ready, lut_a, lut_d, lut_we, cfg_busy, cfg_done, cfg_err, lut_configured
    );
endinterface

// File: rtl/lut_cfg_ctrl.sv
// Loads one truth table per handshake into a bank of LUTRAMs, one bit per cycle,
// and keeps sticky per-LUT "fully loaded" flags. All outputs come straight from flops.
module lut_cfg_ctrl #(
    parameter int NUM_LUTS = 8,
    parameter int LUT_K    = 6,
    parameter int ID_W     = 3
) (
    input logic           clk,
    input logic           rst,
    lut_cfg_ctrl_if.slave cfg_bus
);
    localparam int DEPTH = 2**LUT_K;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [LUT_K-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0]    shadow_q, shadow_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [LUT_K-1:0]    a_q, a_d;
    logic                d_q, d_d;
    logic [NUM_LUTS-1:0] we_q, we_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [NUM_LUTS-1:0] cfgd_q, cfgd_d;
    logic                id_ok;

    function automatic logic [NUM_LUTS-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_LUTS-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    assign id_ok = (32'(cfg_bus.cfg_lut_id) < 32'(NUM_LUTS));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        id_d     = id_q;
        a_d      = a_q;
        d_d      = d_q;
        we_d     = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cfgd_d   = cfgd_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_bus.cfg_valid && ready_q) begin
                    if (id_ok) begin
                        // Address 0 is issued on the accepting edge, so the counter
                        // already points at the next address to write.
                        shadow_d                     = cfg_bus.cfg_data;
                        id_d                         = cfg_bus.cfg_lut_id;
                        cfgd_d[cfg_bus.cfg_lut_id]   = 1'b0;
                        a_d                          = '0;
                        d_d                          = cfg_bus.cfg_data[0];
                        we_d                         = onehot(cfg_bus.cfg_lut_id);
                        cnt_d                        = LUT_K'(1);
                        state_d                      = S_WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // Counter wrapped to zero: the last address has already been issued.
                if (cnt_q == '0) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    cfgd_d[id_q] = 1'b1;
                end else if (!cfg_bus.cfg_pause) begin
                    a_d   = cnt_q;
                    d_d   = shadow_q[cnt_q];
                    we_d  = onehot(id_q);
                    cnt_d = cnt_q + LUT_K'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            d_q      <= 1'b0;
            we_q     <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cfgd_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            id_q     <= id_d;
            a_q      <= a_d;
            d_q      <= d_d;
            we_q     <= we_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cfgd_q   <= cfgd_d;
        end
    end

    assign cfg_bus.cfg_ready      = ready_q;
    assign cfg_bus.lut_a          = a_q;
    assign cfg_bus.lut_d          = d_q;
    assign cfg_bus.lut_we         = we_q;
    assign cfg_bus.cfg_busy       = busy_q;
    assign cfg_bus.cfg_done       = done_q;
    assign cfg_bus.cfg_err        = err_q;
    assign cfg_bus.lut_configured = cfgd_q;
endmodule

// File: doc/lut_cfg_ctrl.md
Name: lut_cfg_ctrl

Overview:
Configuration sequencer for the overlay's LUTRAM-based elut_custom cells. It accepts one 64-bit truth table per transaction over a valid/ready handshake. It then drives the shared write port (a, d, we) of a bank of NUM_LUTS LUTRAMs for 2**LUT_K cycles, one bit per cycle, to load the selected LUT. It sits between the bitstream loader and the LUT bank, and tracks which LUTs have been fully programmed.

Parameters:
NUM_LUTS, 8, number of LUTRAMs in the bank sharing lut_a/lut_d; one write enable per LUT.
LUT_K, 6, LUT input count; depth = 2**LUT_K entries.
ID_W, 3, width of cfg_lut_id; must satisfy 2**ID_W >= NUM_LUTS.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
cfg_valid  in  1  truth-table word valid.
cfg_ready  out  1  controller can accept a word.
cfg_lut_id  in  ID_W  target LUT index.
cfg_data  in  2**LUT_K  truth table; bit i is the LUT output for address i.
cfg_pause  in  1  stalls the write sequence; sampled only in WRITE.
lut_a  out  LUT_K  write address to all LUTRAMs.
lut_d  out  1  write data to all LUTRAMs.
lut_we  out  NUM_LUTS  one-hot write enable.
cfg_busy  out  1  high in WRITE and DONE.
cfg_done  out  1  one-cycle pulse when a LUT load completes.
cfg_err  out  1  one-cycle pulse on an out-of-range cfg_lut_id.
lut_configured  out  NUM_LUTS  sticky per-LUT "fully loaded" flags.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, cfg_ready=1 (the first cycle after reset is IDLE).
  - lut_a=0, lut_d=0, lut_we=0, cfg_busy=0, cfg_done=0, cfg_err=0, lut_configured=0.
  - Internal address counter and shadow data register cleared.
  - Reset during WRITE aborts immediately; LUT contents are left partial, and the flag for that LUT stays 0.
- All outputs are registered.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - cfg_ready=1 and lut_we=0.
  - On cfg_valid & cfg_ready with cfg_lut_id < NUM_LUTS: latch cfg_data and id, clear the counter, clear lut_configured[id], go to WRITE.
  - On cfg_valid & cfg_ready with cfg_lut_id >= NUM_LUTS: cfg_err=1 for the next cycle, word discarded, stay IDLE.
- WRITE:
  - cfg_ready=0, cfg_busy=1.
  - Each non-paused cycle: lut_a=cnt, lut_d=shadow[cnt], lut_we=one-hot(id), then cnt increments.
  - When cfg_pause=1 in a cycle: lut_we=0 for that cycle, and cnt and lut_a hold.
  - After the write with cnt=2**LUT_K-1 is issued, go to DONE; the counter wraps to 0 and never overruns.
- DONE (one cycle):
  - lut_we=0, cfg_done=1, cfg_busy=1, cfg_ready=0.
  - lut_configured[id] is set.
  - Next state IDLE.
- Latency with no pauses:
  - Handshake at edge T.
  - Writes are visible on lut_we during cycles T+1..T+64, addresses 0..63 ascending.
  - cfg_done during cycle T+65.
  - cfg_ready=1 again in cycle T+66.
  - Each pause cycle adds exactly one cycle.
- Input hold rules:
  - cfg_valid while cfg_ready=0 is ignored; the upstream must hold the word until it is accepted.
  - cfg_data changes after acceptance have no effect.
- Reprogramming an already configured LUT is legal: its flag drops at acceptance and is re-set at DONE.
- Only one lut_we bit is ever high, and only in WRITE.

Test Plan:
1. Reset, then load id=2 with data 64'hDEAD_BEEF_0123_4567, no pauses -> lut_we=8'h04 for exactly 64 cycles, lut_a 0..63, lut_d equals data bit lut_a; cfg_done pulses once at T+65; lut_configured=8'h04; a read of the target LUTRAM returns the data.
2. Load id=5 with 64'hAAAA_AAAA_AAAA_AAAA, cfg_pause high on the cycles where lut_a=10 and lut_a=11 -> lut_we low for 2 cycles; lut_a holds at 10 until released, then continues; cfg_done at T+67; no address skipped or duplicated.
3. cfg_lut_id=7 with NUM_LUTS=6 -> cfg_err pulses for 1 cycle, lut_we stays 0, cfg_ready stays 1, lut_configured unchanged.
4. Assert rst when lut_a=30 during a load of id=1 -> next cycle all outputs are 0, cfg_ready=1, lut_configured[1]=0; a subsequent full load of id=1 completes normally.
5. Hold cfg_valid with a new word during WRITE -> not accepted until cfg_ready returns in cycle T+66; the second load then starts with lut_a=0.
6. Load id=0 with all-ones, then reload id=0 with all-zeros -> lut_configured[0] drops at the second acceptance and re-sets at DONE; the final LUT contents are all zero.
